// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Size codes are byte counts from the MEM stage.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FETCH
  } state_t;

  localparam logic [2:0] SZ_NONE = 3'd0;
  localparam logic [2:0] SZ_BYTE = 3'd1;
  localparam logic [2:0] SZ_HALF = 3'd2;
  localparam logic [2:0] SZ_WORD = 3'd4;

  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus between the arbiter (master)
// and the memory (slave).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              m_req;
  logic              m_we;
  logic [3:0]        m_be;
  logic [ADDR_W-3:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_ack;
  logic [31:0]       m_rdata;

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_ack, m_rdata
  );

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_ack, m_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses: byte enables,
// replicated store data and the alignment fault flag.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  read_size,
  input  logic [2:0]  write_size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic        we,
  output logic        misalign
);

  logic [2:0] sz;

  always_comb begin
    be         = 4'b0000;
    lane_wdata = wdata;
    misalign   = (read_size != SZ_NONE) &&
                 (write_size != SZ_NONE);
    we         = (write_size != SZ_NONE);
    sz         = (read_size != SZ_NONE) ?
                 read_size : write_size;
    unique case (sz)
      SZ_NONE: ;
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        if (addr_lo[0]) misalign = 1'b1;
      end
      SZ_WORD: begin
        be = 4'b1111;
        if (addr_lo != 2'b00) misalign = 1'b1;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one memory port, data first.
// Define MEM_ARB_TIMEOUT_EN for the m_ack watchdog.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic [2:0]        d_read_size,
  input  logic [2:0]        d_write_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_done,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              d_stall,
  output logic              bus_err,
  mem_port_arbiter_if.master mem
);

  state_t            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic [31:0]       drd_q, drd_d, ird_q, ird_d;
  logic              fin;
  logic              d_any;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic              lane_we, lane_mis;

  assign d_any = |(d_read_size | d_write_size);

  mem_lane_align u_align (
    .read_size  (d_read_size),
    .write_size (d_write_size),
    .addr_lo    (d_addr[1:0]),
    .wdata      (d_wdata),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .we         (lane_we),
    .misalign   (lane_mis)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  wire unused_cfg = &{1'b0, (TIMEOUT > 0)};
`endif

  wire unused_addr = &{1'b0, if_addr[1:0]};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    drd_d   = drd_q;
    ird_d   = ird_q;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // the held request is not resampled in its done cycle
        if (d_any && !done_q) begin
          if (lane_mis) begin
            mis_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = DATA;
            req_d   = 1'b1;
            we_d    = lane_we;
            be_d    = lane_be;
            addr_d  = d_addr[ADDR_W-1:2];
            wdata_d = lane_wdata;
          end
        end else if (if_req) begin
          state_d = FETCH;
          req_d   = 1'b1;
          we_d    = 1'b0;
          be_d    = 4'b1111;
          addr_d  = if_addr[ADDR_W-1:2];
        end
      end
      DATA, FETCH: begin
        if (mem.m_ack) begin
          fin = 1'b1;
          if (state_q == DATA) drd_d = mem.m_rdata;
          else                 ird_d = mem.m_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MEM_ARB_TIMEOUT_EN
    wd_d  = '0;
    err_d = 1'b0;
    if (state_q != IDLE && !mem.m_ack) begin
      if (wd_q == WD_LAST) begin
        fin   = 1'b1;
        err_d = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
`endif
    if (fin) begin
      state_d = IDLE;
      req_d   = 1'b0;
      we_d    = 1'b0;
      be_d    = 4'b0000;
      done_d  = (state_q == DATA);
      valid_d = (state_q == FETCH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      drd_q   <= '0;
      ird_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      drd_q   <= drd_d;
      ird_q   <= ird_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign mem.m_req   = req_q;
  assign mem.m_we    = we_q;
  assign mem.m_be    = be_q;
  assign mem.m_addr  = addr_q;
  assign mem.m_wdata = wdata_q;
  assign d_done      = done_q;
  assign d_misalign  = mis_q;
  assign d_rdata     = drd_q;
  assign if_valid    = valid_q;
  assign if_rdata    = ird_q;
  assign d_stall     = d_any && !done_q;

endmodule
